load_store_unit: RTL and testbench

//   MEM-stage initiator for the byte-addressed data memory. Accepts one load/store request at a time

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/load_store_unit_byte_lane.sv | 39 +++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared state encoding, RISC-V load/store funct3 codes and an access-size helper
// for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STORE  = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        STORE  = ST_STORE,
        RMW_RD = ST_RMW_RD,
        RMW_WR = ST_RMW_WR,
        RESP   = ST_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access width in bytes; the low two funct3 bits carry the size for every encoding.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane logic: extends load data and merges sub-doubleword store
// data into the doubleword read back from memory.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] mem_word,
    input  logic [63:0] store_data,
    output logic [63:0] load_value,
    output logic [63:0] merged_word
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        load_value = '0;
        case (funct3)
            F3_B:    load_value = {{56{mem_word[7]}},  mem_word[7:0]};
            F3_H:    load_value = {{48{mem_word[15]}}, mem_word[15:0]};
            F3_W:    load_value = {{32{mem_word[31]}}, mem_word[31:0]};
            F3_D:    load_value = mem_word;
            F3_BU:   load_value = {56'd0, mem_word[7:0]};
            F3_HU:   load_value = {48'd0, mem_word[15:0]};
            F3_WU:   load_value = {32'd0, mem_word[31:0]};
            default: load_value = '0;
        endcase
    end

    // The memory has no byte enables, so bytes above the store width are written back unchanged.
    always_comb begin
        merged_word = store_data;
        case (funct3[1:0])
            2'b00:   merged_word = {mem_word[63:8],  store_data[7:0]};
            2'b01:   merged_word = {mem_word[63:16], store_data[15:0]};
            2'b10:   merged_word = {mem_word[63:32], store_data[31:0]};
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the byte-addressed data memory; one request in flight,
// read-modify-write for sb/sh/sw. Optional alignment trap: `define MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_write_data,
    output logic              mem_memoryread,
    output logic              mem_memorywrite,
    input  logic [63:0]       mem_read_data
);

    localparam logic [ADDR_W-1:0] LAST_START = ADDR_W'(MEM_BYTES - 8);

    lsu_state_t        state;
    lsu_state_t        state_next;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       merged_q;
    logic [63:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              misaligned;
    logic              req_err;
    logic [63:0]       load_value;
    logic [63:0]       merged_word;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned = (req_addr[3:0] & (size_bytes(req_funct3) - 4'd1)) != 4'd0;
`endif
    end

    assign req_err = (req_funct3 == 3'b111)
                  || (req_write && req_funct3[2])
                  || (req_addr > LAST_START)
                  || misaligned;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_write)
                        state_next = LOAD;
                    else if (size_bytes(req_funct3) == 4'd8)
                        state_next = STORE;
                    else
                        state_next = RMW_RD;
                end
            end
            LOAD, STORE, RMW_WR: state_next = RESP;
            RMW_RD:              state_next = RMW_WR;
            RESP:                state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                rdata_q <= '0;
                err_q   <= req_err;
            end else if (state == LOAD) begin
                rdata_q <= load_value;
            end
        end
    end

    // NOTE: request/datapath registers carry no reset; they are only observed after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
        if (state == RMW_RD)
            merged_q <= merged_word;
    end

    lsu_byte_lane u_byte_lane (
        .funct3      (funct3_q),
        .mem_word    (mem_read_data),
        .store_data  (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // Strobes depend on state alone, so a write in flight at a reset edge still commits.
    always_comb begin
        mem_memoryread  = 1'b0;
        mem_memorywrite = 1'b0;
        mem_address     = '0;
        mem_write_data  = '0;
        case (state)
            LOAD, RMW_RD: begin
                mem_memoryread = 1'b1;
                mem_address    = addr_q;
            end
            STORE: begin
                mem_memorywrite = 1'b1;
                mem_address     = addr_q;
                mem_write_data  = wdata_q;
            end
            RMW_WR: begin
                mem_memorywrite = 1'b1;
                mem_address     = addr_q;
                mem_write_data  = merged_q;
            end
            default: ;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-in-flight
// sequences and randomized traffic checked against a byte-array reference model.
module tb_load_store_unit;

    localparam int MEM_BYTES = 256;
    localparam int ADDR_W    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [63:0]       mem_write_data;
    logic              mem_memoryread;
    logic              mem_memorywrite;
    logic [63:0]       mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_memoryread  (mem_memoryread),
        .mem_memorywrite (mem_memorywrite),
        .mem_read_data   (mem_read_data)
    );

    // Data memory stand-in: combinational little-endian read, write on the clock edge.
    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            if (mem_address + 64'(i) < 64'(MEM_BYTES))
                mem_read_data[8*i +: 8] = mem[int'(mem_address) + i];
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        mem[0] = 8'd188; mem[8] = 8'd22; mem[16] = 8'd33; mem[32] = 8'd115;
        forever begin
            @(posedge clk);
            if (mem_memorywrite)
                for (int i = 0; i < 8; i++)
                    if (mem_address + 64'(i) < 64'(MEM_BYTES))
                        mem[int'(mem_address) + i] <= mem_write_data[8*i +: 8];
        end
    end

    int wr_pulses = 0, rd_pulses = 0, resp_cnt = 0, conflict_cnt = 0, idle_nonzero_cnt = 0;
    always @(negedge clk) begin
        if (mem_memorywrite) wr_pulses++;
        if (mem_memoryread)  rd_pulses++;
        if (resp_valid)      resp_cnt++;
        if (mem_memoryread && mem_memorywrite) conflict_cnt++;
        if (!mem_memoryread && !mem_memorywrite && (mem_address != 0 || mem_write_data != 0))
            idle_nonzero_cnt++;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: applies one request to ref_mem from the access rules directly.
    task automatic ref_apply(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, output logic [63:0] rd, output logic err,
                             output int lat, output int nwr, output int nrd);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        err  = (f3 == 3'b111) || (wr && f3[2]) || (addr > 64'(MEM_BYTES - 8));
`ifdef MISALIGN_TRAP_EN
        if (addr % 64'(size) != 0) err = 1'b1;
`endif
        rd = '0; lat = 1; nwr = 0; nrd = 0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
                lat = (size == 8) ? 2 : 3;
                nwr = 1;
                nrd = (size == 8) ? 0 : 1;
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
                if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'h0 << (8*size));
                rd = v; lat = 2; nrd = 1;
            end
        end
    endtask

    task automatic wait_ready(output logic ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, output logic [63:0] rd, output logic err,
                          output int lat, output int nwr, output int nrd, output logic done);
        int wr0, rd0;
        logic ok;
        done = 1'b0; rd = '0; err = 1'b0; lat = 0;
        wait_ready(ok);
        wr0 = wr_pulses; rd0 = rd_pulses;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 64'($urandom);
        req_wdata = {$urandom, $urandom};
        for (int c = 1; c <= 10 && !done; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                done = 1'b1; lat = c; rd = resp_rdata; err = resp_err;
            end
        end
        nwr = wr_pulses - wr0;
        nrd = rd_pulses - rd0;
    endtask

    // Accept a request, then assert reset in the cycle right after the accept edge.
    task automatic reset_mid(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, input string tag, input int exp_wr);
        int wr0, resp0;
        logic ok;
        wait_ready(ok);
        wr0 = wr_pulses; resp0 = resp_cnt;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after_reset"}, 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_write_pulses"}, 64'(wr_pulses - wr0), 64'(exp_wr));
        check({tag, "_no_resp"}, 64'(resp_cnt - resp0), 64'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        int          nrd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] rd, m_rd;
        logic        err, m_err, done;
        int          lat, nwr, nrd, m_lat, m_nwr, m_nrd, bad;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr, wd;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'd188; ref_mem[8] = 8'd22; ref_mem[16] = 8'd33; ref_mem[32] = 8'd115;

        vecs.push_back('{1'b0, 3'b000, 64'd0,   64'd0, 64'hFFFF_FFFF_FFFF_FFBC, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 3'b100, 64'd0,   64'd0, 64'h0000_0000_0000_00BC, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b1, 3'b011, 64'd24,  64'h1122_3344_5566_7788, 64'd0, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 3'b011, 64'd24,  64'd0, 64'h1122_3344_5566_7788, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b1, 3'b000, 64'd16,  64'hFFFF_FFFF_FFFF_FFAA, 64'd0, 1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 3'b011, 64'd16,  64'd0, 64'h0000_0000_0000_00AA, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 3'b011, 64'd8,   64'd0, 64'd22, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 3'b111, 64'd0,   64'd0, 64'd0, 1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 3'b011, 64'd250, 64'd0, 64'd0, 1'b1, 1, 0, 0});
        vecs.push_back('{1'b1, 3'b100, 64'd0,   64'hFF, 64'd0, 1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 3'b011, 64'd249, 64'd0, 64'd0, 1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 3'b011, 64'd248, 64'd0, 64'd0, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b1, 3'b011, 64'd40,  64'h0102_0304_0506_0708, 64'd0, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 3'b010, 64'd40,  64'hCAFE_F00D_DEAD_BEEF, 64'd0, 1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 3'b010, 64'd40,  64'd0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 3'b110, 64'd40,  64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 3'b011, 64'd40,  64'd0, 64'h0102_0304_DEAD_BEEF, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b1, 3'b001, 64'd16,  64'h1234_8001, 64'd0, 1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 3'b001, 64'd16,  64'd0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 3'b101, 64'd16,  64'd0, 64'h0000_0000_0000_8001, 1'b0, 2, 0, 1});
`ifdef MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b001, 64'd1,   64'd0, 64'd0, 1'b1, 1, 0, 0});
`else
        vecs.push_back('{1'b0, 3'b001, 64'd1,   64'd0, 64'd0, 1'b0, 2, 0, 1});
`endif

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",      64'(req_ready),       64'd1);
        check("reset_resp_valid", 64'(resp_valid),      64'd0);
        check("reset_resp_rdata", resp_rdata,           64'd0);
        check("reset_resp_err",   64'(resp_err),        64'd0);
        check("reset_memread",    64'(mem_memoryread),  64'd0);
        check("reset_memwrite",   64'(mem_memorywrite), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            ref_apply(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, m_rd, m_err, m_lat, m_nwr, m_nrd);
            do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, err, lat, nwr, nrd, done);
            check($sformatf("vec%0d_done", i),     64'(done), 64'd1);
            check($sformatf("vec%0d_rdata", i),    rd,        vecs[i].rdata);
            check($sformatf("vec%0d_err", i),      64'(err),  64'(vecs[i].err));
            check($sformatf("vec%0d_latency", i),  64'(lat),  64'(vecs[i].lat));
            check($sformatf("vec%0d_wr_pulses", i), 64'(nwr), 64'(vecs[i].nwr));
            check($sformatf("vec%0d_rd_pulses", i), 64'(nrd), 64'(vecs[i].nrd));
        end

        // Reset in RMW_RD of sh drops the store; reset in STORE of sd still commits it.
        reset_mid(1'b1, 3'b001, 64'd32, 64'hBEEF, "rst_rmw_rd", 0);
        do_req(1'b0, 3'b011, 64'd32, 64'd0, rd, err, lat, nwr, nrd, done);
        check("rst_rmw_rd_ld32", rd, 64'd115);
        reset_mid(1'b1, 3'b011, 64'd48, 64'h5A5A_0000_1111_2222, "rst_store", 1);
        ref_apply(1'b1, 3'b011, 64'd48, 64'h5A5A_0000_1111_2222, m_rd, m_err, m_lat, m_nwr, m_nrd);
        do_req(1'b0, 3'b011, 64'd48, 64'd0, rd, err, lat, nwr, nrd, done);
        check("rst_store_ld48", rd, 64'h5A5A_0000_1111_2222);

        for (int n = 0; n < 300; n++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255))
                                               : 64'($urandom_range(0, 63));
            wd   = {$urandom, $urandom};
            ref_apply(wr, f3, addr, wd, m_rd, m_err, m_lat, m_nwr, m_nrd);
            do_req(wr, f3, addr, wd, rd, err, lat, nwr, nrd, done);
            check($sformatf("rnd%0d_done", n),    64'(done), 64'd1);
            check($sformatf("rnd%0d_rdata", n),   rd,        m_rd);
            check($sformatf("rnd%0d_err", n),     64'(err),  64'(m_err));
            check($sformatf("rnd%0d_latency", n), 64'(lat),  64'(m_lat));
            check($sformatf("rnd%0d_wr", n),      64'(nwr),  64'(m_nwr));
            check($sformatf("rnd%0d_rd", n),      64'(nrd),  64'(m_nrd));
        end

        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_memory_bytes_differing", 64'(bad), 64'd0);
        check("strobe_conflict_cycles", 64'(conflict_cnt), 64'd0);
        check("idle_bus_nonzero_cycles", 64'(idle_nonzero_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
